// File: rtl/if_id_fifo_if.sv
// rtl/if_id_fifo_if.sv - valid/ready instruction channel between fetch, queue and decode
//
// One instance carries {pc, instruction} entries in one direction.
//   valid      master -> slave  entry present
//   ready      slave  -> master entry accepted this cycle
//   inst_addr  master -> slave  pc of the entry
//   inst       master -> slave  instruction word

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface if_id_fifo_if #(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst;

  modport master (output valid, inst_addr, inst, input ready);
  modport slave  (input valid, inst_addr, inst, output ready);
endinterface

// File: rtl/if_id_fifo.sv
// rtl/if_id_fifo.sv - DEPTH-entry IF/ID instruction queue with flush and bubble output
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   flush_jump_i   jump/branch redirect, empties the queue
//   flush_int_i    interrupt redirect, empties the queue
//   fetch_if       slave side: fetch pushes {pc, inst}; ready = !full
//   dec_if         master side: decode pops the head; valid = !empty,
//                  head shows BUBBLE_ADDR/BUBBLE_INST when empty
//   count_o        occupancy 0..DEPTH
//   almost_full_o  occupancy >= DEPTH-1

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REBOOT_ADDR
`define REBOOT_ADDR 32'h0000_0000
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module if_id_fifo #(
  parameter int                ADDR_W      = `ADDR_WIDTH,
  parameter int                DATA_W      = `DATA_WIDTH,
  parameter int                DEPTH       = 4,
  parameter logic [ADDR_W-1:0] BUBBLE_ADDR = `REBOOT_ADDR,
  parameter logic [DATA_W-1:0] BUBBLE_INST = `NOP,
  parameter int                CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_jump_i,
  input  logic             flush_int_i,
  if_id_fifo_if.slave      fetch_if,
  if_id_fifo_if.master     dec_if,
  output logic [CNT_W-1:0] count_o,
  output logic             almost_full_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] occ;
  logic [ENT_W-1:0] head;
  logic             empty, full, push, pop, flush;

  // Pointers carry one extra bit: equal indices with differing MSBs means full.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                 (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);
  // Modulo-2*DEPTH difference of the pointers is exactly the occupancy.
  assign occ   = wptr_q - rptr_q;

  assign flush = flush_jump_i | flush_int_i;
  assign push  = fetch_if.valid & ~full;
  assign pop   = ~empty & dec_if.ready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is never reset; the bubble mux below covers the empty case.
  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      mem_q[wptr_q[IDX_W-1:0]] <= {fetch_if.inst_addr, fetch_if.inst};
    end
  end

  assign head               = mem_q[rptr_q[IDX_W-1:0]];
  assign dec_if.inst_addr   = empty ? BUBBLE_ADDR : head[ENT_W-1:DATA_W];
  assign dec_if.inst        = empty ? BUBBLE_INST : head[DATA_W-1:0];
  assign dec_if.valid       = ~empty;
  assign fetch_if.ready     = ~full;
  assign count_o            = CNT_W'(occ);
  assign almost_full_o      = (occ >= PTR_W'(DEPTH - 1));

endmodule

// File: doc/if_id_fifo.md
# if_id_fifo

Parametrised IF/ID decoupling stage that replaces the single-entry fetch/decode latch with a DEPTH-entry instruction queue and valid/ready handshakes on both sides. It sits between the fetch unit, which pushes {pc, instruction} pairs, and the decode stage, which pops them. When empty, decode sees the canonical bubble (`REBOOT_ADDR` / `NOP`). A jump or interrupt flush discards every queued entry in one cycle.

## Interface
- ADDR_W, default `ADDR_WIDTH`: width of the instruction address.
- DATA_W, default `DATA_WIDTH`: width of the instruction word.
- DEPTH, default 4: number of queue entries; power of two, ≥2.
- BUBBLE_ADDR, default `REBOOT_ADDR`: address presented while empty.
- BUBBLE_INST, default `NOP`: instruction presented while empty.
- CNT_W, default $clog2(DEPTH+1): width of count_o.

- clk_i  in  1  sole clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- flush_jump_i  in  1  branch/jump redirect; discard all entries.
- flush_int_i  in  1  interrupt redirect; discard all entries.
- valid_i  in  1  fetch presents an entry.
- ready_o  out  1  queue can accept; equals !full.
- inst_addr_i  in  ADDR_W  pc of the pushed entry.
- inst_i  in  DATA_W  pushed instruction word.
- valid_o  out  1  head entry is valid; equals !empty.
- ready_i  in  1  decode consumes the head entry this cycle (de-asserted when decode is stalled).
- inst_addr_o  out  ADDR_W  head pc, or BUBBLE_ADDR when empty.
- inst_o  out  DATA_W  head instruction, or BUBBLE_INST when empty.
- count_o  out  CNT_W  current occupancy, 0..DEPTH.
- almost_full_o  out  1  count ≥ DEPTH-1; used by fetch to throttle.

## Operation
- Storage: DEPTH × (ADDR_W + DATA_W) array, with read and write pointers of $clog2(DEPTH)+1 bits.
  - The extra MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2·DEPTH.
- push = valid_i & ready_o. pop = valid_o & ready_i. flush = flush_jump_i | flush_int_i.
- Priority per edge:
  1. reset
  2. flush
  3. push/pop
- Flush:
  - Read pointer, write pointer and count all go to 0.
  - Any same-cycle push is dropped, even though ready_o was high.
  - Any same-cycle pop is discarded; decode must ignore the handshake in that cycle.
- Push only: write entry at wptr, wptr+1, count+1.
- Pop only: rptr+1, count-1.
- Push and pop in the same cycle:
  - Both pointers advance and count is unchanged.
  - This is legal at any occupancy 1..DEPTH-1.
  - At full, ready_o=0, so push cannot occur; there is no pass-through on pop.
  - At empty, valid_o=0, so pop cannot occur; the pushed entry appears next cycle (no bypass).
- Outputs:
  - inst_addr_o / inst_o are a combinational read of mem[rptr] when !empty, otherwise BUBBLE_ADDR / BUBBLE_INST.
  - Array contents are never reset; the bubble mux guarantees defined outputs.
- Decode stall maps to ready_i=0. The head entry holds stable until popped or flushed.
- Fetch must hold valid_i, inst_addr_i and inst_i stable until push.

## Timing
- Reset (asynchronous assert, synchronous release by upstream):
  - Immediately: count_o=0, valid_o=0, ready_o=1, almost_full_o=0, inst_addr_o=BUBBLE_ADDR, inst_o=BUBBLE_INST.
  - Reset mid-operation discards all entries with the same values.
- Latency: an entry pushed at edge k is on the outputs with valid_o=1 after edge k, i.e. in cycle k+1.
- Throughput: one push and one pop per cycle sustained; DEPTH entries buffer a decode stall of up to DEPTH cycles with no fetch back-pressure.
- Flush asserted before edge k: after edge k the outputs show the bubble, count_o=0 and ready_o=1. The first post-flush push may occur at edge k+1.
- ready_o, valid_o, count_o and almost_full_o depend only on registered state. There is no combinational path from valid_i or ready_i to any output.

## Test plan
- Reset then fill, DEPTH=4:
  - Push pc 0x100, 0x104, 0x108, 0x10C with ready_i=0 → count_o goes 1,2,3,4.
  - almost_full_o rises at count 3; ready_o=0 at count 4.
  - Outputs hold pc 0x100, inst of the first push.
- Drain in order: from full, ready_i=1 for 4 cycles → inst_addr_o sequence 0x100, 0x104, 0x108, 0x10C, then valid_o=0 with BUBBLE_ADDR / NOP.
- Wrap-around streaming: push and pop every cycle for 20 entries at count 2 → count_o stays 2 and the pc sequence is contiguous with no loss or duplication across pointer wrap.
- Flush priority: at count 3, assert flush_jump_i together with valid_i=1 (pc 0x200) and ready_i=1 → next cycle count_o=0 and valid_o=0; pc 0x200 never appears. Repeat with flush_int_i for the same result.
- Async reset mid-stream: at count 2, drop rst_n_i between edges → outputs go to the bubble with count_o=0 before the next edge. After release, a push of pc 0x300 appears one cycle later.
- Full boundary: at count 4, hold valid_i=1 with ready_i=1 for one cycle → pop only, count_o=3. The held entry is accepted on the following edge and count_o returns to 4.
